sobel_lb_ctrl: RTL and testbench

SOBEL_LB_CTRL -- requirements
Module: sobel_lb_ctrl

---
 rtl/sobel_pkg.sv | 6 +
 rtl/lb_ram.sv | 28 ++
 rtl/sobel_lb_ctrl.sv | 98 +++++++++
 tb/tb_sobel_lb_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// sobel_pkg: shared defaults and FSM state encoding for the Sobel line-buffer block
package sobel_pkg;
    localparam int COLORDEPTH_DEF = 8;
    localparam int MAX_WIDTH_DEF = 2048;
    typedef enum logic [1:0] {WAIT_VS, FILL0, FILL1, RUN} state_t;
endpackage

// File: rtl/lb_ram.sv
// lb_ram: simple dual-port read-first line buffer with registered read data
module lb_ram
    import sobel_pkg::*;
#(
    parameter int DW = COLORDEPTH_DEF,
    parameter int DEPTH = MAX_WIDTH_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input logic clk,
    input logic rst,
    input logic we,
    input logic [AW-1:0] wa,
    input logic [DW-1:0] wd,
    input logic re,
    input logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);
    logic [DW-1:0] mem [DEPTH];
    // storage is never cleared; consumers gate stale contents themselves
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end
    // read data register returns the pre-write value on an address collision
    always_ff @(posedge clk) begin
        if (rst) rd <= '0;
        else if (re) rd <= mem[ra];
    end
endmodule

// File: rtl/sobel_lb_ctrl.sv
// sobel_lb_ctrl: two-line buffer controller producing 3-row pixel columns for a Sobel kernel
module sobel_lb_ctrl
    import sobel_pkg::*;
#(
    parameter int COLORDEPTH = COLORDEPTH_DEF,
    parameter int MAX_WIDTH = MAX_WIDTH_DEF
) (
    input logic clk,
    input logic rst,
    input logic [COLORDEPTH-1:0] px_i,
    input logic dv_i,
    input logic hs_i,
    input logic vs_i,
    output logic [2:0][COLORDEPTH-1:0] vect_o,
    output logic dv_o,
    output logic hs_o,
    output logic vs_o,
    output logic rows_valid_o,
    output logic ovf_o
);
    localparam int CW = $clog2(MAX_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(MAX_WIDTH - 1);
    state_t state, state_n;
    logic sel, sel_q, full, vs_q, dv_q;
    logic [CW-1:0] col;
    logic [COLORDEPTH-1:0] px_q, rd_a, rd_b;
    logic vs_rise, line_end, wr;
    assign vs_rise = vs_i & ~vs_q;
    assign line_end = dv_q & ~dv_i;
    assign wr = dv_i & ~full;
    // frame fill sequencing; a new frame start outranks a coincident line end
    always_comb begin
        state_n = state;
        if (vs_rise) state_n = FILL0;
        else if (line_end) state_n = state == FILL0 ? FILL1 : state == FILL1 ? RUN : state;
    end
    // state, buffer select, column counter and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= WAIT_VS;
            sel <= 1'b0;
            col <= '0;
            full <= 1'b0;
            ovf_o <= 1'b0;
            vs_q <= 1'b0;
            dv_q <= 1'b0;
        end else begin
            state <= state_n;
            vs_q <= vs_i;
            dv_q <= dv_i;
            if (vs_rise) begin
                sel <= 1'b0;
                col <= '0;
                full <= 1'b0;
                ovf_o <= 1'b0;
            end else if (line_end) begin
                sel <= ~sel;
                col <= '0;
                full <= 1'b0;
            end else if (dv_i) begin
                if (full) ovf_o <= 1'b1;
                else if (col == LAST) full <= 1'b1;
                else col <= col + 1'b1;
            end
        end
    end
    // one-cycle aligned outputs; the pixel path only moves on valid data so it holds in gaps
    always_ff @(posedge clk) begin
        if (rst) begin
            px_q <= '0;
            sel_q <= 1'b0;
            dv_o <= 1'b0;
            hs_o <= 1'b0;
            vs_o <= 1'b0;
            rows_valid_o <= 1'b0;
        end else begin
            dv_o <= dv_i;
            hs_o <= hs_i;
            vs_o <= vs_i;
            rows_valid_o <= state_n == RUN;
            if (dv_i) begin
                px_q <= px_i;
                sel_q <= sel;
            end
        end
    end
    assign vect_o[0] = px_q;
    assign vect_o[1] = sel_q ? rd_a : rd_b;
    assign vect_o[2] = sel_q ? rd_b : rd_a;
    lb_ram #(.DW(COLORDEPTH), .DEPTH(MAX_WIDTH)) u_ram_a (
        .clk(clk), .rst(rst), .we(wr & ~sel), .wa(col), .wd(px_i),
        .re(dv_i), .ra(col), .rd(rd_a)
    );
    lb_ram #(.DW(COLORDEPTH), .DEPTH(MAX_WIDTH)) u_ram_b (
        .clk(clk), .rst(rst), .we(wr & sel), .wa(col), .wd(px_i),
        .re(dv_i), .ra(col), .rd(rd_b)
    );
endmodule

// File: tb/tb_sobel_lb_ctrl.sv
// tb_sobel_lb_ctrl: table, directed and randomized checks of the Sobel line-buffer controller
module tb_sobel_lb_ctrl;
    import sobel_pkg::*;
    localparam int CD = 8;
    typedef struct {
        logic dv, vs;
        logic [CD-1:0] px;
        logic edv, erv, cv;
        logic [2:0][CD-1:0] ev;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, dv = 1'b0, hs = 1'b0, vs = 1'b0;
    logic [CD-1:0] px = '0;
    logic [2:0][CD-1:0] vect, vect8;
    logic dvo, hso, vso, rv, ovf, dvo8, hso8, vso8, rv8, ovf8;
    int n_chk = 0, n_fail = 0;
    vec_t tbl[$];
    logic [CD-1:0] cl[64], p1[64], p2[64];
    int cl_n, p1_n, p2_n, colm, nlines;
    bit in_frame, pdv, pvs;
    logic [CD-1:0] last_px;

    always #5 clk = ~clk;

    sobel_lb_ctrl dut (
        .clk(clk), .rst(rst), .px_i(px), .dv_i(dv), .hs_i(hs), .vs_i(vs),
        .vect_o(vect), .dv_o(dvo), .hs_o(hso), .vs_o(vso), .rows_valid_o(rv), .ovf_o(ovf)
    );
    sobel_lb_ctrl #(.MAX_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .px_i(px), .dv_i(dv), .hs_i(hs), .vs_i(vs),
        .vect_o(vect8), .dv_o(dvo8), .hs_o(hso8), .vs_o(vso8), .rows_valid_o(rv8), .ovf_o(ovf8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic v, input logic [CD-1:0] p);
        dv = d;
        vs = v;
        px = p;
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic d, input logic v, input logic [CD-1:0] p,
                                input logic edv, input logic erv, input logic cv,
                                input logic [2:0][CD-1:0] ev);
        vec_t e;
        e.dv = d; e.vs = v; e.px = p; e.edv = edv; e.erv = erv; e.cv = cv; e.ev = ev;
        tbl.push_back(e);
    endfunction

    task automatic rnd_step(input logic d, input logic h, input logic v, input logic [CD-1:0] p);
        bit vsr, le, r1_ok, r2_ok, erv;
        logic [CD-1:0] r1, r2;
        vsr = v && !pvs;
        le = pdv && !d;
        r1_ok = d && colm < p1_n;
        r2_ok = d && colm < p2_n;
        r1 = p1[colm];
        r2 = p2[colm];
        if (vsr) begin
            in_frame = 1; nlines = 0; cl_n = 0; p1_n = 0; p2_n = 0; colm = 0;
        end else if (le) begin
            if (in_frame && nlines < 2) nlines++;
            p2 = p1; p2_n = p1_n; p1 = cl; p1_n = cl_n; cl_n = 0; colm = 0;
        end
        if (d && !vsr && colm < 64) begin
            cl[colm] = p; colm++; cl_n = colm;
        end
        if (d) last_px = p;
        erv = in_frame && nlines >= 2;
        pvs = v;
        pdv = d;
        hs = h;
        drive(d, v, p);
        chk("rnd_dv", dvo, d);
        chk("rnd_hs", hso, h);
        chk("rnd_vs", vso, v);
        chk("rnd_rows_valid", rv, erv);
        chk("rnd_cur", vect[0], last_px);
        if (erv && r1_ok) chk("rnd_row1", vect[1], r1);
        if (erv && r2_ok) chk("rnd_row2", vect[2], r2);
    endtask

    initial begin
        add(0, 1, 0, 0, 0, 0, '0);
        add(0, 0, 0, 0, 0, 0, '0);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 4; k++)
                add(1, 0, CD'(16 * n + k), 1, n == 2, n == 2,
                    {CD'(16 * (n - 2) + k), CD'(16 * (n - 1) + k), CD'(16 * n + k)});
            add(0, 0, 0, 0, n >= 1, 0, '0);
        end

        rst = 1'b1;
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("rst_vect", vect, 0);
        chk("rst_dv", dvo, 0);
        chk("rst_hs", hso, 0);
        chk("rst_vs", vso, 0);
        chk("rst_rows_valid", rv, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_state", 32'(dut.state), 32'(WAIT_VS));
        chk("rst_sel", dut.sel, 0);
        chk("rst_col", 32'(dut.col), 0);
        rst = 1'b0;
        drive(0, 0, 0);

        foreach (tbl[i]) begin
            drive(tbl[i].dv, tbl[i].vs, tbl[i].px);
            chk($sformatf("tbl%0d_dv", i), dvo, tbl[i].edv);
            chk($sformatf("tbl%0d_rows_valid", i), rv, tbl[i].erv);
            if (tbl[i].cv) chk($sformatf("tbl%0d_vect", i), vect, tbl[i].ev);
        end

        drive(1, 0, 8'h30);
        drive(1, 0, 8'h31);
        chk("run_rows_valid", rv, 1);
        drive(1, 1, 8'h32);
        chk("vsmid_state", 32'(dut.state), 32'(FILL0));
        chk("vsmid_sel", dut.sel, 0);
        chk("vsmid_col", 32'(dut.col), 0);
        chk("vsmid_rows_valid", rv, 0);
        drive(1, 1, 8'h33);
        chk("vsmid_next_dv", dvo, 1);
        chk("vsmid_next_rows_valid", rv, 0);
        drive(0, 0, 0);

        drive(0, 0, 0);
        drive(0, 1, 0);
        drive(0, 0, 0);
        for (int k = 0; k < 3; k++) drive(1, 0, CD'(k));
        drive(0, 1, 0);
        chk("simul_state", 32'(dut.state), 32'(FILL0));
        chk("simul_sel", dut.sel, 0);
        chk("simul_col", 32'(dut.col), 0);
        drive(0, 0, 0);
        chk("simul_hold_state", 32'(dut.state), 32'(FILL0));

        for (int k = 0; k < 4; k++) drive(1, 0, CD'(8'h40 + k));
        drive(0, 0, 0);
        chk("fill1_state", 32'(dut.state), 32'(FILL1));
        drive(1, 0, 8'h50);
        drive(1, 0, 8'h51);
        rst = 1'b1;
        drive(1, 0, 8'h52);
        rst = 1'b0;
        chk("midrst_vect", vect, 0);
        chk("midrst_dv", dvo, 0);
        chk("midrst_rows_valid", rv, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_state", 32'(dut.state), 32'(WAIT_VS));
        chk("midrst_col", 32'(dut.col), 0);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 4; k++) begin
                drive(1, 0, CD'(16 * n + k));
                chk("wait_rows_valid", rv, 0);
            end
            drive(0, 0, 0);
            chk("wait_gap_rows_valid", rv, 0);
        end
        chk("wait_state", 32'(dut.state), 32'(WAIT_VS));

        drive(0, 1, 0);
        drive(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, CD'(8'h60 + k));
            chk("gap_cur", vect[0], 8'h60 + k);
            chk("gap_col_adv", 32'(dut.col), 1);
            drive(0, 0, 0);
            chk("gap_cur_held", vect[0], 8'h60 + k);
            chk("gap_col_clr", 32'(dut.col), 0);
        end

        drive(0, 1, 0);
        drive(0, 0, 0);
        chk("ovf_pre", ovf8, 0);
        for (int k = 0; k < 10; k++) begin
            drive(1, 0, CD'(8'h70 + k));
            if (k == 7) begin
                chk("ovf_after8", ovf8, 0);
                chk("ovf_col8", 32'(dut8.col), 7);
            end
            if (k == 8) chk("ovf_after9", ovf8, 1);
            if (k == 9) begin
                chk("ovf_after10", ovf8, 1);
                chk("ovf_col_sat", 32'(dut8.col), 7);
                chk("ovf_big_dut", ovf, 0);
            end
        end
        drive(0, 0, 0);
        chk("ovf_mem7", dut8.u_ram_a.mem[7], 8'h77);
        chk("ovf_sticky", ovf8, 1);
        drive(0, 1, 0);
        chk("ovf_clr", ovf8, 0);
        drive(0, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0);
        rst = 1'b0;
        in_frame = 0; nlines = 0; cl_n = 0; p1_n = 0; p2_n = 0; colm = 0;
        pdv = 0; pvs = 0; last_px = '0;
        for (int s = 0; s < 180; s++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int c = 0; c < int'($urandom_range(1, 2)); c++)
                    rnd_step(0, 1'($urandom), 1, '0);
                rnd_step(0, 1'($urandom), 0, '0);
            end else begin
                for (int c = 0; c < int'($urandom_range(1, 12)); c++)
                    rnd_step(1, 1'($urandom), 0, CD'($urandom));
                for (int c = 0; c < int'($urandom_range(1, 3)); c++)
                    rnd_step(0, 1'($urandom), 0, '0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
